// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified memory-port arbiter of the multicycle MIPS core.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYC = 16;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter bounding how long the arbiter waits for a memory acknowledge.
module mem_arb_timer #(
  parameter int LOAD_VAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LOAD_VAL + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LOAD_VAL);

  logic [CNT_W-1:0] count;

  // Saturates at zero so expired stays asserted until the next clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= LOAD;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one memory port with a bounded ack wait.
// Define ARB_ROUND_ROBIN_EN to alternate between requesters on simultaneous requests.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              owner,
  output logic              timeout_err
);

  arb_state_t        state, state_next;
  logic              take_dm, expired, start, finish;
  logic [DATA_W-1:0] resp_data;

  mem_arb_timer #(.LOAD_VAL(TIMEOUT_CYC - 1)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (state == ACCESS),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (if_req || dm_req) state_next = ACCESS;
      ACCESS:  if (mem_ack || expired) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    take_dm = dm_req && (!if_req || (owner == OWN_IF));
`else
    take_dm = dm_req;
`endif
  end

  assign start  = (state == IDLE) && (if_req || dm_req);
  assign finish = (state == ACCESS) && (mem_ack || expired);
  // Stores and timed-out accesses hand back zero.
  assign resp_data = (mem_ack && !mem_we) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_gnt      <= 1'b0;
      dm_gnt      <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      busy        <= 1'b0;
      owner       <= OWN_IF;
      timeout_err <= 1'b0;
    end else begin
      if_gnt  <= 1'b0;
      dm_gnt  <= 1'b0;
      busy    <= (state_next != IDLE);
      mem_req <= (state_next == ACCESS);
      if (start) begin
        owner <= take_dm ? OWN_DM : OWN_IF;
        if (take_dm) begin
          mem_we    <= dm_we;
          mem_be    <= dm_be;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_be    <= BE_WORD;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      if (finish) begin
        if (!mem_ack) timeout_err <= 1'b1;
        if (owner == OWN_DM) begin
          dm_gnt   <= 1'b1;
          dm_rdata <= resp_data;
        end else begin
          if_gnt   <= 1'b1;
          if_rdata <= resp_data;
        end
      end
    end
  end

endmodule
